// File: rtl/rgb_sram_packer.sv
// Packs a valid/ready stream of 24-bit RGB pixels into 16-bit SRAM words,
// three words per pixel pair ({R0,G0}, {B0,R1}, {G1,B1}) at consecutive addresses.
module rgb_sram_packer #(
  parameter int unsigned NUM_PIXELS = 76800,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SRAM_base_address,
  input  logic              Pixel_valid,
  output logic              Pixel_ready,
  input  logic [7:0]        Pixel_R,
  input  logic [7:0]        Pixel_G,
  input  logic [7:0]        Pixel_B,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              Busy,
  output logic              Done
);

  if ((NUM_PIXELS == 0) || ((NUM_PIXELS % 2) != 0)) begin : g_bad_num_pixels
    $error("rgb_sram_packer: NUM_PIXELS must be even and nonzero");
  end

  localparam int unsigned CNT_W = (NUM_PIXELS < 2) ? 2 : $clog2(NUM_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_ODD2,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        hold_g_q, hold_g_d;
  logic [7:0]        hold_b_q, hold_b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_n_q, we_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_inc;

  assign Pixel_ready     = (state_q == S_EVEN) || (state_q == S_ODD);
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = data_q;
  assign SRAM_we_n       = we_n_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign count_inc       = count_q + CNT_W'(2);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      hold_g_q <= '0;
      hold_b_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      hold_g_q <= hold_g_d;
      hold_b_q <= hold_b_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_n_q   <= we_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Address/data registers only move when a write is scheduled; we_n drops for that one cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    hold_g_d = hold_g_q;
    hold_b_d = hold_b_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_n_d   = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          ptr_d   = SRAM_base_address;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_EVEN;
        end
      end
      S_EVEN: begin
        if (Pixel_valid) begin
          addr_d   = ptr_q;
          data_d   = {Pixel_R, Pixel_G};
          we_n_d   = 1'b0;
          hold_b_d = Pixel_B;
          ptr_d    = ptr_q + ADDR_W'(1);
          state_d  = S_ODD;
        end
      end
      S_ODD: begin
        if (Pixel_valid) begin
          addr_d   = ptr_q;
          data_d   = {hold_b_q, Pixel_R};
          we_n_d   = 1'b0;
          hold_g_d = Pixel_G;
          hold_b_d = Pixel_B;
          ptr_d    = ptr_q + ADDR_W'(1);
          state_d  = S_ODD2;
        end
      end
      S_ODD2: begin
        addr_d  = ptr_q;
        data_d  = {hold_g_q, hold_b_q};
        we_n_d  = 1'b0;
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_inc;
        state_d = (count_inc == CNT_W'(NUM_PIXELS)) ? S_DONE : S_EVEN;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
